fanout_fork_buf: RTL

//  Registered eager-fork stage for one ready/valid stream feeding up to NUM_OUT consumers.
//  - Branch k is active when cfg_en[k] & cfg_sel[k][SEL_BIT].
//  - Upstream ready is the combine of all active branch readies.
//  - Fans out from one interconnect track to several tiles. Adds buffering and per-branch
//    "taken" tracking, so each consumer may accept the word in a different cycle.

---
 rtl/fanout_fork_buf_if.sv | 29 ++
 rtl/fanout_fork_buf.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fanout_fork_buf_if.sv
// Stream bundle between one upstream producer and the NUM_OUT fanout consumers.
// Latency: none, this is only a bundle of wires.
// Backpressure: in_ready (upstream) and per-branch out_ready (downstream).
// Ports:
//   in_valid/in_data/in_ready     upstream ready/valid word
//   out_valid/out_data/out_ready  per-branch valid, shared payload, per-branch ready
// Modports: master = environment side (drives in_valid/in_data/out_ready),
//           slave  = fork stage side (drives in_ready/out_valid/out_data).
interface fanout_fork_buf_if #(
  parameter int NUM_OUT = 20,
  parameter int DATA_W  = 16
);
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fanout_fork_buf.sv
// Registered eager-fork stage: one ready/valid stream fanned out to NUM_OUT branches.
// Latency: 1 cycle in->out; each branch may take the word in a different cycle.
// Backpressure: word retires once every branch of its mask has taken it; upstream
//   stalls until then (or until the skid slot fills when FANOUT_FORK_SKID_EN is defined).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   strm         upstream/downstream handshake bundle (slave modport)
//   cfg_en       per-branch enable
//   cfg_sel      packed per-branch select fields, bit SEL_BIT routes branch onto this track
//   flush        synchronous discard of buffered word(s) and taken flags
//   xfer_cnt     count of fully delivered words (wraps)
// Option: FANOUT_FORK_SKID_EN adds a second (skid) entry so in_ready comes from flops only.
module fanout_fork_buf #(
  parameter int NUM_OUT = 20,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 8,
  parameter int SEL_BIT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fanout_fork_buf_if.slave         strm,
  input  logic [NUM_OUT-1:0]       cfg_en,
  input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
  input  logic                     flush,
  output logic [CNT_W-1:0]         xfer_cnt
);

  typedef struct packed {
    logic [NUM_OUT-1:0] mask;
    logic [DATA_W-1:0]  dat;
  } entry_t;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t             state, state_d;
  entry_t             head_q, head_d, new_ent;
  logic               head_vld;
  logic [NUM_OUT-1:0] taken, taken_d;
  logic [NUM_OUT-1:0] sel_bits, in_mask, fire;
  logic               done, accept, load;
  // Select bits other than the routing bit carry no meaning for this track.
  logic               unused_sel;

`ifdef FANOUT_FORK_SKID_EN
  entry_t             skid_q, skid_d;
  logic               skid_vld, skid_vld_d;
`endif

  always_comb begin
    sel_bits = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_bits[k] = cfg_sel[k*SEL_W + SEL_BIT];
    end
  end

  assign unused_sel = ^cfg_sel;
  assign in_mask    = cfg_en & sel_bits;
  assign new_ent    = {in_mask, strm.in_data};
  assign head_vld   = (state == HOLD);

  assign strm.out_valid = {NUM_OUT{head_vld}} & head_q.mask & ~taken;
  assign strm.out_data  = head_q.dat;
  assign fire           = strm.out_valid & strm.out_ready;
  // Done once every masked branch has either taken the word earlier or takes it now.
  assign done           = head_vld & ((taken | fire) == head_q.mask);

`ifdef FANOUT_FORK_SKID_EN
  // Only the skid occupancy decides readiness, so out_ready never reaches in_ready.
  assign strm.in_ready = ~flush & ~skid_vld;
`else
  assign strm.in_ready = ~flush & (~head_vld | done);
`endif

  assign accept = strm.in_valid & strm.in_ready;
  // A word routed to no branch is consumed upstream and simply vanishes.
  assign load   = accept & (|in_mask);

  always_comb begin
    state_d = state;
    head_d  = head_q;
    taken_d = taken | fire;
`ifdef FANOUT_FORK_SKID_EN
    skid_d     = skid_q;
    skid_vld_d = skid_vld;
`endif
    if (flush) begin
      state_d = EMPTY;
      taken_d = '0;
`ifdef FANOUT_FORK_SKID_EN
      skid_vld_d = 1'b0;
`endif
    end else begin
      if (done) begin
        state_d = EMPTY;
        taken_d = '0;
      end
`ifdef FANOUT_FORK_SKID_EN
      if (done && skid_vld) begin
        head_d     = skid_q;
        state_d    = HOLD;
        skid_vld_d = 1'b0;
      end
      if (load) begin
        if (state_d == HOLD) begin
          skid_d     = new_ent;
          skid_vld_d = 1'b1;
        end else begin
          head_d  = new_ent;
          state_d = HOLD;
          taken_d = '0;
        end
      end
`else
      if (load) begin
        head_d  = new_ent;
        state_d = HOLD;
        taken_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      head_q   <= '0;
      taken    <= '0;
      xfer_cnt <= '0;
`ifdef FANOUT_FORK_SKID_EN
      skid_q   <= '0;
      skid_vld <= 1'b0;
`endif
    end else begin
      state <= state_d;
      head_q <= head_d;
      taken <= taken_d;
      if (!flush && done) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
`ifdef FANOUT_FORK_SKID_EN
      skid_q   <= skid_d;
      skid_vld <= skid_vld_d;
`endif
    end
  end

endmodule
